// File: rtl/pixel_pkg.sv
// Shared types and constants for the 24-bit pixel to 32-bit word packer.
package pixel_pkg;

    localparam int PIX_W      = 24;
    localparam int DATA_WIDTH = 32;

    typedef enum logic {
        PACK  = 1'b0,
        FLUSH = 1'b1
    } pack_state_t;

    typedef struct packed {
        logic [7:0] b;
        logic [7:0] g;
        logic [7:0] r;
    } pixel_t;

endpackage

// File: rtl/output_reg.sv
// One-entry valid/ready register slice carrying a data word plus user and last sidebands.
module output_reg #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_user,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_user,
    output logic                  out_last
);

    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  user_q;
    logic                  last_q;

    // Free when empty or when the held word leaves this cycle.
    assign in_ready = !valid_q || out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            user_q  <= 1'b0;
            last_q  <= 1'b0;
        end else if (in_valid && in_ready) begin
            valid_q <= 1'b1;
            data_q  <= in_data;
            user_q  <= in_user;
            last_q  <= in_last;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_user  = user_q;
    assign out_last  = last_q;

endmodule

// File: rtl/pixel_packer.sv
// Packs 24-bit {b,g,r} pixels into 32-bit words (4 pixels -> 3 words) with
// SOF/EOL sidebands, end-of-line flush and misaligned-SOF recovery.
module pixel_packer #(
    parameter int PIX_W      = 24,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            r,
    input  logic [7:0]            g,
    input  logic [7:0]            b,
    input  logic                  first,
    input  logic                  last_x,
    input  logic                  last_y,
    input  logic                  valid,
    output logic                  ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_user,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  frame_done,
    output logic                  align_err
);

    import pixel_pkg::*;

    pack_state_t      state_q, state_d;
    logic [1:0]       phase_q, phase_d;
    logic [PIX_W-1:0] resid_q, resid_d;
    logic             sof_q, sof_d;
    logic             lasty_q, lasty_d;
    logic             eof_q;
    logic             align_q;

    pixel_t           pix;
    logic [PIX_W-1:0] pix_w;
    logic             acc;
    logic             sof_cur;
    logic [1:0]       phase_eff;

    logic                  ld_valid;
    logic                  ld_ready;
    logic [DATA_WIDTH-1:0] ld_data;
    logic                  ld_user;
    logic                  ld_last;
    logic                  ld_eof;

    assign pix       = '{b: b, g: g, r: r};
    assign pix_w     = pix;
    assign ready     = !reset && ld_ready && (state_q == PACK);
    assign acc       = valid && ready;
    assign sof_cur   = first || sof_q;
    // An SOF always restarts packing at phase 0, dropping any residual.
    assign phase_eff = first ? 2'd0 : phase_q;

    // The residual is kept zero-padded so the flush word is simply {8'h00, resid_q}.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        resid_d  = resid_q;
        sof_d    = sof_q;
        lasty_d  = lasty_q;
        ld_valid = 1'b0;
        ld_data  = '0;
        ld_user  = 1'b0;
        ld_last  = 1'b0;
        ld_eof   = 1'b0;
        if (state_q == FLUSH) begin
            ld_valid = 1'b1;
            ld_data  = {8'h00, resid_q};
            ld_last  = 1'b1;
            ld_eof   = lasty_q;
            if (ld_ready) begin
                state_d = PACK;
                resid_d = '0;
            end
        end else if (acc) begin
            unique case (phase_eff)
                2'd0: begin
                    if (last_x) begin
                        ld_valid = 1'b1;
                        ld_data  = {8'h00, pix_w};
                        ld_user  = sof_cur;
                        ld_last  = 1'b1;
                        ld_eof   = last_y;
                        sof_d    = 1'b0;
                        resid_d  = '0;
                        phase_d  = 2'd0;
                    end else begin
                        resid_d  = pix_w;
                        sof_d    = sof_cur;
                        phase_d  = 2'd1;
                    end
                end
                2'd1: begin
                    ld_valid = 1'b1;
                    ld_data  = {pix_w[7:0], resid_q};
                    ld_user  = sof_cur;
                    sof_d    = 1'b0;
                    resid_d  = {8'h00, pix_w[23:8]};
                    phase_d  = last_x ? 2'd0 : 2'd2;
                    if (last_x) begin
                        state_d = FLUSH;
                        lasty_d = last_y;
                    end
                end
                2'd2: begin
                    ld_valid = 1'b1;
                    ld_data  = {pix_w[15:0], resid_q[15:0]};
                    ld_user  = sof_cur;
                    sof_d    = 1'b0;
                    resid_d  = {16'h0000, pix_w[23:16]};
                    phase_d  = last_x ? 2'd0 : 2'd3;
                    if (last_x) begin
                        state_d = FLUSH;
                        lasty_d = last_y;
                    end
                end
                default: begin
                    ld_valid = 1'b1;
                    ld_data  = {pix_w, resid_q[7:0]};
                    ld_user  = sof_cur;
                    ld_last  = last_x;
                    ld_eof   = last_x && last_y;
                    sof_d    = 1'b0;
                    resid_d  = '0;
                    phase_d  = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= PACK;
            phase_q <= 2'd0;
            resid_q <= '0;
            sof_q   <= 1'b0;
            lasty_q <= 1'b0;
            eof_q   <= 1'b0;
            align_q <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            resid_q <= resid_d;
            sof_q   <= sof_d;
            lasty_q <= lasty_d;
            align_q <= acc && first && (phase_q != 2'd0);
            if (ld_valid && ld_ready) begin
                eof_q <= ld_eof;
            end
        end
    end

    output_reg #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_out (
        .clk      (clk),
        .reset    (reset),
        .in_valid (ld_valid),
        .in_ready (ld_ready),
        .in_data  (ld_data),
        .in_user  (ld_user),
        .in_last  (ld_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_user (out_user),
        .out_last (out_last)
    );

    assign frame_done = out_valid && out_ready && out_last && eof_q;
    assign align_err  = align_q;

endmodule

// File: tb/tb_pixel_packer.sv
// Directed bench for pixel_packer: packing layout, line flush, stall, SOF handling and frame end.
module tb_pixel_packer;

    logic        clk;
    logic        reset;
    logic [7:0]  r, g, b;
    logic        first, last_x, last_y, valid;
    logic        ready;
    logic [31:0] out_data;
    logic        out_user, out_last, out_valid;
    logic        out_ready;
    logic        frame_done, align_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [34:0] wq[$];
    int fd_cnt    = 0;
    int align_cnt = 0;
    int rlow_cnt  = 0;

    pixel_packer #(.PIX_W(24), .DATA_WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .r         (r),
        .g         (g),
        .b         (b),
        .first     (first),
        .last_x    (last_x),
        .last_y    (last_y),
        .valid     (valid),
        .ready     (ready),
        .out_data  (out_data),
        .out_user  (out_user),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_done(frame_done),
        .align_err (align_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every transferred word as {frame_done, user, last, data}.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) wq.push_back({frame_done, out_user, out_last, out_data});
            if (frame_done) fd_cnt++;
            if (align_err) align_cnt++;
            if (!ready) rlow_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_word(input string tag, input int idx, input logic [31:0] d,
                            input logic u, input logic l);
        logic [34:0] w;
        w = (idx < wq.size()) ? wq[idx] : 35'h7_FFFF_FFFF;
        chk(tag, {30'd0, w[33:0]}, {30'd0, u, l, d});
    endtask

    task automatic send(input logic [23:0] p, input logic f, input logic lx, input logic ly);
        int n;
        n = 0;
        r = p[7:0]; g = p[15:8]; b = p[23:16];
        first = f; last_x = lx; last_y = ly; valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!ready && n < 100);
        if (!ready) chk("send_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        valid = 1'b0; first = 1'b0; last_x = 1'b0; last_y = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int base, fd0, al0, rl0;
    logic [31:0] hold_d;
    logic stable, rlow;

    initial begin
        reset = 1'b1; valid = 1'b0; first = 1'b0; last_x = 1'b0; last_y = 1'b0;
        r = '0; g = '0; b = '0; out_ready = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_data", {32'd0, out_data}, 64'd0);
        chk("rst_flags", {59'd0, out_user, out_last, frame_done, align_err, ready}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {63'd0, ready}, 64'd1);
        idle(1);

        // Four pixels -> three words; W1 = {P2[15:0], P1[23:8]} = 0x88994455
        base = wq.size();
        send(24'h112233, 1'b1, 1'b0, 1'b0);
        send(24'h445566, 1'b0, 1'b0, 1'b0);
        send(24'h778899, 1'b0, 1'b0, 1'b0);
        send(24'hAABBCC, 1'b0, 1'b0, 1'b0);
        idle(4);
        chk("basic_count", 64'(wq.size() - base), 64'd3);
        chk_word("basic_w0", base + 0, 32'h66112233, 1'b1, 1'b0);
        chk_word("basic_w1", base + 1, 32'h88994455, 1'b0, 1'b0);
        chk_word("basic_w2", base + 2, 32'hAABBCC77, 1'b0, 1'b0);

        // Six-pixel line ending at phase 1 -> flush word
        base = wq.size(); rl0 = rlow_cnt;
        send(24'h010203, 1'b0, 1'b0, 1'b0);
        send(24'h040506, 1'b0, 1'b0, 1'b0);
        send(24'h070809, 1'b0, 1'b0, 1'b0);
        send(24'h0A0B0C, 1'b0, 1'b0, 1'b0);
        send(24'h0D0E0F, 1'b0, 1'b0, 1'b0);
        send(24'h101112, 1'b0, 1'b1, 1'b0);
        idle(5);
        chk("line6_count", 64'(wq.size() - base), 64'd5);
        chk_word("line6_w0", base + 0, 32'h06010203, 1'b0, 1'b0);
        chk_word("line6_w2", base + 2, 32'h0A0B0C07, 1'b0, 1'b0);
        chk_word("line6_w3", base + 3, 32'h120D0E0F, 1'b0, 1'b0);
        chk_word("line6_flush", base + 4, 32'h00001011, 1'b0, 1'b1);
        chk("line6_ready_low", 64'(rlow_cnt - rl0), 64'd1);

        // Downstream stall of 10 cycles mid-line
        base = wq.size();
        send(24'h112233, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b0;
        send(24'h445566, 1'b0, 1'b0, 1'b0);
        fork
            send(24'h778899, 1'b0, 1'b0, 1'b0);
            begin
                @(negedge clk);
                hold_d = out_data; stable = 1'b1; rlow = !ready;
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    if (out_data !== hold_d) stable = 1'b0;
                    if (ready) rlow = 1'b0;
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        send(24'hAABBCC, 1'b0, 1'b0, 1'b0);
        idle(4);
        chk("stall_stable", {63'd0, stable}, 64'd1);
        chk("stall_ready_low", {63'd0, rlow}, 64'd1);
        chk("stall_hold_data", {32'd0, hold_d}, 64'h66112233);
        chk("stall_count", 64'(wq.size() - base), 64'd3);
        chk_word("stall_w1", base + 1, 32'h88994455, 1'b0, 1'b0);
        chk_word("stall_w2", base + 2, 32'hAABBCC77, 1'b0, 1'b0);

        // One-pixel line carrying both SOF and EOL
        base = wq.size();
        send(24'h123456, 1'b1, 1'b1, 1'b0);
        idle(3);
        chk("single_count", 64'(wq.size() - base), 64'd1);
        chk_word("single_w", base, 32'h00123456, 1'b1, 1'b1);

        // SOF arriving at phase 2
        base = wq.size(); al0 = align_cnt;
        send(24'h111111, 1'b0, 1'b0, 1'b0);
        send(24'h222222, 1'b0, 1'b0, 1'b0);
        send(24'hA1B2C3, 1'b1, 1'b0, 1'b0);
        send(24'hD4E5F6, 1'b0, 1'b0, 1'b0);
        send(24'h070809, 1'b0, 1'b0, 1'b0);
        send(24'h0A0B0C, 1'b0, 1'b0, 1'b0);
        idle(4);
        chk("align_pulses", 64'(align_cnt - al0), 64'd1);
        chk("align_count", 64'(wq.size() - base), 64'd4);
        chk_word("align_pre", base + 0, 32'h22111111, 1'b0, 1'b0);
        chk_word("align_w0", base + 1, 32'hF6A1B2C3, 1'b1, 1'b0);
        chk_word("align_w1", base + 2, 32'h0809D4E5, 1'b0, 1'b0);
        chk_word("align_w2", base + 3, 32'h0A0B0C07, 1'b0, 1'b0);

        // Frame of 2 lines x 8 pixels
        base = wq.size(); fd0 = fd_cnt;
        for (int ln = 1; ln <= 2; ln++) begin
            for (int i = 0; i < 8; i++) begin
                send({8'(ln), 8'h00, 8'(i)}, (ln == 1) && (i == 0), i == 7, ln == 2);
            end
        end
        idle(4);
        chk("frame_count", 64'(wq.size() - base), 64'd12);
        chk("frame_done_cnt", 64'(fd_cnt - fd0), 64'd1);
        chk_word("frame_w0", base + 0, 32'h01010000, 1'b1, 1'b0);
        chk_word("frame_eol1", base + 5, 32'h01000701, 1'b0, 1'b1);
        chk_word("frame_l2w0", base + 6, 32'h01020000, 1'b0, 1'b0);
        chk_word("frame_eol2", base + 11, 32'h02000702, 1'b0, 1'b1);
        chk("frame_done_w12", (base + 11 < wq.size()) ? {63'd0, wq[base + 11][34]} : 64'd0, 64'd1);

        // Reset mid-line drops the residual
        base = wq.size();
        send(24'h333333, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        send(24'h444444, 1'b1, 1'b1, 1'b0);
        idle(3);
        chk("rstmid_count", 64'(wq.size() - base), 64'd1);
        chk_word("rstmid_w", base, 32'h00444444, 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
